// File: rtl/anton_neopixel_apb_ctrl.sv
// WS2812 strip driver: 24-bit GRB pixel buffer and CTRL register on a
// zero-wait-state APB slave, one-shot or looping frame serialiser.
//
// Ports:
//   CLK_10MHZ      shared APB / serialiser clock
//   APB_PRESERN    synchronous active-low reset
//   APB_PADDR      byte address (3n+0=G, 3n+1=R, 3n+2=B, all-ones=CTRL)
//   APB_PSELx      slave select
//   APB_PENABLE    access phase
//   APB_PWRITE     1=write, 0=read
//   APB_PWDATA     write data
//   APB_PRDATA     read data, registered on the setup edge
//   APB_PREADY     tied high
//   APB_PSLVERR    unmapped address, access phase only
//   NEO_DATA       serial strip data
//   VERBOSE_STATE  high during the latch gap
//   FRAME_DONE     pulse on the last latch cycle
module anton_neopixel_apb_ctrl #(
  parameter int PIXELS_MAX  = 5,
  parameter int ADDR_BITS   = 8,
  parameter int TBIT_TICKS  = 12,
  parameter int T0H_TICKS   = 3,
  parameter int T1H_TICKS   = 8,
  parameter int RESET_TICKS = 600
) (
  input  logic                 CLK_10MHZ,
  input  logic                 APB_PRESERN,
  input  logic [ADDR_BITS-1:0] APB_PADDR,
  input  logic                 APB_PSELx,
  input  logic                 APB_PENABLE,
  input  logic                 APB_PWRITE,
  input  logic [7:0]           APB_PWDATA,
  output logic [7:0]           APB_PRDATA,
  output logic                 APB_PREADY,
  output logic                 APB_PSLVERR,
  output logic                 NEO_DATA,
  output logic                 VERBOSE_STATE,
  output logic                 FRAME_DONE
);

  localparam int NBYTES = 3 * PIXELS_MAX;
  localparam int IW = $clog2(NBYTES);
  localparam int TW =
    (TBIT_TICKS > 1) ? $clog2(TBIT_TICKS) : 1;
  localparam int LW =
    (RESET_TICKS > 1) ? $clog2(RESET_TICKS) : 1;
  localparam logic [ADDR_BITS-1:0] CTRL_ADDR = '1;
  localparam logic [IW-1:0] LAST_BASE =
    IW'(3 * (PIXELS_MAX - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_TX,
    S_LATCH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]    r_buf [2**IW];
  logic [23:0]   r_shift;
  logic [TW-1:0] r_tick;
  logic [4:0]    r_bit;
  logic [IW-1:0] r_base;
  logic [LW-1:0] r_lat;
  logic          r_loop;
  logic [7:0]    r_prdata;
  logic          r_slverr;

  logic          w_setup;
  logic          w_wr;
  logic          w_in_buf;
  logic          w_is_ctrl;
  logic          w_mapped;
  logic          w_start;
  logic          w_busy;
  logic [IW-1:0] w_aidx;
  logic [IW-1:0] w_ld_base;
  logic [23:0]   w_ld_word;
  logic          w_tick_last;
  logic          w_bit_last;
  logic          w_pix_last;
  logic          w_lat_last;
  logic          w_neo;
  logic          w_verbose;
  logic          w_done;

  assign w_setup   = APB_PSELx & ~APB_PENABLE;
  assign w_wr      = APB_PSELx & APB_PENABLE
                   & APB_PWRITE;
  assign w_in_buf  = APB_PADDR < ADDR_BITS'(NBYTES);
  assign w_is_ctrl = APB_PADDR == CTRL_ADDR;
  assign w_mapped  = w_in_buf | w_is_ctrl;
  assign w_aidx    = APB_PADDR[IW-1:0];
  assign w_start   = w_wr & w_is_ctrl & APB_PWDATA[0];
  assign w_busy    = r_state != S_IDLE;

  assign w_tick_last = r_tick == TW'(TBIT_TICKS - 1);
  assign w_bit_last  = r_bit == 5'd23;
  assign w_pix_last  = r_base == LAST_BASE;
  assign w_lat_last  = r_lat == LW'(RESET_TICKS - 1);

  // LOAD fetches pixel 0; inside TX the next pixel is
  // fetched on the final tick of the current one.
  assign w_ld_base = (r_state == S_LOAD) ? '0
                   : r_base + IW'(3);
  assign w_ld_word = {r_buf[w_ld_base],
                      r_buf[w_ld_base + IW'(1)],
                      r_buf[w_ld_base + IW'(2)]};

  // No reset: buffer contents survive a reset. A load
  // in the same cycle as a write sees the old byte.
  always_ff @(posedge CLK_10MHZ) begin
    if (w_wr & w_in_buf) begin
      r_buf[w_aidx] <= APB_PWDATA;
    end
  end

  always_ff @(posedge CLK_10MHZ) begin
    if (!APB_PRESERN) begin
      r_prdata <= '0;
      r_slverr <= 1'b0;
      r_loop   <= 1'b0;
    end else begin
      r_slverr <= w_setup & ~w_mapped;
      if (w_setup) begin
        unique case (1'b1)
          w_in_buf:  r_prdata <= r_buf[w_aidx];
          w_is_ctrl: r_prdata <= {w_busy, 5'b0,
                                  r_loop, 1'b0};
          default:   r_prdata <= '0;
        endcase
      end
      if (w_wr & w_is_ctrl) begin
        r_loop <= APB_PWDATA[1];
      end
    end
  end

  always_ff @(posedge CLK_10MHZ) begin
    if (!APB_PRESERN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK_10MHZ) begin
    if (!APB_PRESERN) begin
      r_shift <= '0;
      r_tick  <= '0;
      r_bit   <= '0;
      r_base  <= '0;
      r_lat   <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          r_shift <= w_ld_word;
          r_tick  <= '0;
          r_bit   <= '0;
          r_base  <= '0;
        end
        S_TX: begin
          if (w_tick_last) begin
            r_tick <= '0;
            if (w_bit_last) begin
              r_bit <= '0;
              if (!w_pix_last) begin
                r_shift <= w_ld_word;
                r_base  <= w_ld_base;
              end
            end else begin
              r_shift <= {r_shift[22:0], 1'b0};
              r_bit   <= r_bit + 5'd1;
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_LATCH: begin
          r_lat <= w_lat_last ? '0 : r_lat + LW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    w_neo     = 1'b0;
    w_verbose = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_next = S_TX;
      end
      S_TX: begin
        w_neo = r_tick < (r_shift[23]
                ? TW'(T1H_TICKS) : TW'(T0H_TICKS));
        if (w_tick_last & w_bit_last & w_pix_last)
          w_next = S_LATCH;
      end
      S_LATCH: begin
        w_verbose = 1'b1;
        if (w_lat_last) begin
          w_done = 1'b1;
          w_next = r_loop ? S_LOAD : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign APB_PRDATA    = r_prdata;
  assign APB_PREADY    = 1'b1;
  assign APB_PSLVERR   = r_slverr;
  assign NEO_DATA      = w_neo;
  assign VERBOSE_STATE = w_verbose;
  assign FRAME_DONE    = w_done;

endmodule

// File: tb/tb_anton_neopixel_apb_ctrl.sv
// Bench for anton_neopixel_apb_ctrl: frame-offset reference
// model, per-cycle compare, directed and random APB traffic.
module tb_anton_neopixel_apb_ctrl;

  localparam int PIX = 5;
  localparam int TB = 12;
  localparam int T0 = 3;
  localparam int T1 = 8;
  localparam int RT = 600;
  localparam int PBITS = 24 * TB;
  localparam int TXC = PBITS * PIX;
  localparam int FL = 1 + TXC + RT;
  localparam int NB = 3 * PIX;
  localparam logic [7:0] CA = 8'hFF;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] paddr = '0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] pwdata = '0;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       neo;
  logic       verb;
  logic       done;

  anton_neopixel_apb_ctrl dut (
    .CLK_10MHZ     (clk),
    .APB_PRESERN   (rstn),
    .APB_PADDR     (paddr),
    .APB_PSELx     (psel),
    .APB_PENABLE   (penable),
    .APB_PWRITE    (pwrite),
    .APB_PWDATA    (pwdata),
    .APB_PRDATA    (prdata),
    .APB_PREADY    (pready),
    .APB_PSLVERR   (pslverr),
    .NEO_DATA      (neo),
    .VERBOSE_STATE (verb),
    .FRAME_DONE    (done)
  );

  always #50 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int hi_total = 0;
  int done_q[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model: frame position as an offset from
  // the LOAD cycle, pixel words snapshotted at load time.
  logic [7:0]  mem [NB];
  logic [23:0] m_pix [PIX];
  bit          m_in = 0;
  int          m_t = 0;
  bit          m_loop = 0;
  logic [7:0]  m_prd = '0;
  bit          m_err = 0;
  bit          m_valid = 0;

  always @(posedge clk) begin : mdl
    bit wr, setup, mapped, busy_o, loop_o;
    int a, p;
    if (!rstn) begin
      m_in = 0; m_t = 0; m_loop = 0;
      m_prd = '0; m_err = 0; m_valid = 1;
    end else begin
      a = int'(paddr);
      wr = psel && penable && pwrite;
      setup = psel && !penable;
      mapped = (a < NB) || (paddr == CA);
      busy_o = m_in;
      loop_o = m_loop;
      if (m_in) begin
        p = m_t / PBITS;
        if (m_t % PBITS == 0 && p < PIX)
          m_pix[p] = {mem[3*p], mem[3*p+1], mem[3*p+2]};
        m_t++;
        if (m_t == FL) begin
          m_t = 0;
          m_in = loop_o;
        end
      end else if (wr && paddr == CA && pwdata[0]) begin
        m_in = 1;
        m_t = 0;
      end
      if (setup) begin
        if (!mapped) m_prd = '0;
        else if (paddr == CA)
          m_prd = {busy_o, 5'b0, loop_o, 1'b0};
        else m_prd = mem[a];
      end
      m_err = setup && !mapped;
      if (wr && mapped) begin
        if (paddr == CA) m_loop = pwdata[1];
        else mem[a] = pwdata;
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit en, ev, ed;
    int k, p, j, tk;
    cyc++;
    if (done) done_q.push_back(cyc);
    if (neo) hi_total++;
    if (m_valid) begin
      en = 0;
      if (m_in && m_t >= 1 && m_t <= TXC) begin
        k = m_t - 1;
        p = k / PBITS;
        j = (k % PBITS) / TB;
        tk = k % TB;
        en = tk < (m_pix[p][23-j] ? T1 : T0);
      end
      ev = m_in && m_t > TXC;
      ed = m_in && m_t == FL - 1;
      chk("NEO_DATA", neo, en);
      chk("VERBOSE_STATE", verb, ev);
      chk("FRAME_DONE", done, ed);
      chk("PRDATA", prdata, m_prd);
      chk("PSLVERR", pslverr, m_err);
      chk("PREADY", pready, 1);
    end
  end

  task automatic apb_write(input logic [7:0] a,
                           input logic [7:0] d);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1;
    paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [7:0] a,
                          output logic [7:0] d,
                          output logic e);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    d = prdata;
    e = pslverr;
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic wait_count(input string nm,
                            input int target);
    int i = 0;
    while (done_q.size() < target && i < 3 * FL) begin
      @(posedge clk);
      i++;
    end
    checks++;
    if (done_q.size() < target) begin
      errs++;
      $display("FAIL %s: FRAME_DONE count %0d want %0d",
               nm, done_q.size(), target);
    end
  endtask

  task automatic rand_ops(input int n, input bit lp);
    int stop;
    int r;
    logic [7:0] a, d;
    logic e;
    stop = cyc + n;
    while (cyc < stop) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
      end else if (r < 6) begin
        a = 8'($urandom_range(0, NB - 1));
        apb_write(a, 8'($urandom));
      end else if (r == 6) begin
        a = 8'($urandom_range(NB, 254));
        apb_write(a, 8'($urandom));
      end else if (r == 7) begin
        apb_read(8'($urandom), d, e);
      end else if (r == 8) begin
        a = 8'($urandom_range(0, NB));
        if (a == 8'(NB)) a = CA;
        apb_read(a, d, e);
      end else begin
        d = 8'($urandom);
        d[1] = lp;
        apb_write(CA, d);
      end
    end
  endtask

  initial begin
    #(100 * 90000);
    $display("FAIL watchdog: run exceeded cycle limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] d;
    logic e;
    int c0, h0, n0, n1;

    repeat (3) @(posedge clk);
    #1 rstn = 1;

    apb_read(CA, d, e);
    chk("reset_ctrl", d, 8'h00);
    chk("reset_err", e, 0);

    // Pixel 0 = 80 00 01, rest zero: two '1' bits.
    for (int i = 0; i < NB; i++)
      apb_write(8'(i), (i == 0) ? 8'h80
                : (i == 2) ? 8'h01 : 8'h00);
    apb_write(CA, 8'h01);
    c0 = cyc;
    h0 = hi_total;
    n0 = done_q.size();
    apb_read(CA, d, e);
    chk("busy_read", d, 8'h80);
    wait_count("oneshot_done", n0 + 1);
    if (done_q.size() > n0)
      chk("oneshot_len", done_q[n0] - c0, FL);
    chk("oneshot_high", hi_total - h0, 2*T1 + 118*T0);
    apb_read(CA, d, e);
    chk("busy_fall", d, 8'h00);

    apb_write(8'd4, 8'hA5);
    apb_read(8'd4, d, e);
    chk("rd4_data", d, 8'hA5);
    chk("rd4_err", e, 0);
    apb_write(8'd15, 8'h5A);
    apb_read(8'd15, d, e);
    chk("rd15_data", d, 8'h00);
    chk("rd15_err", e, 1);
    apb_read(8'd14, d, e);
    chk("rd14_kept", d, 8'h00);

    // Coherency and START while busy.
    for (int i = 0; i < NB; i++)
      apb_write(8'(i), 8'h00);
    apb_write(CA, 8'h01);
    c0 = cyc;
    h0 = hi_total;
    n0 = done_q.size();
    repeat (40) @(posedge clk);
    apb_write(8'd6, 8'hFF);
    apb_write(8'd0, 8'hAA);
    apb_write(CA, 8'h01);
    wait_count("coh_done", n0 + 1);
    if (done_q.size() > n0)
      chk("coh_len", done_q[n0] - c0, FL);
    chk("coh_high", hi_total - h0, 120*T0 + 8*(T1-T0));
    n0 = done_q.size();
    repeat (FL + 100) @(posedge clk);
    chk("no_requeue", done_q.size(), n0);
    apb_write(CA, 8'h01);
    h0 = hi_total;
    wait_count("coh2_done", n0 + 1);
    chk("coh2_high", hi_total - h0,
        120*T0 + 12*(T1-T0));

    // Looping with traffic, then LOOP cleared.
    n0 = done_q.size();
    apb_write(CA, 8'h03);
    rand_ops(3000, 1);
    wait_count("loop_done", n0 + 3);
    if (done_q.size() >= n0 + 3) begin
      chk("loop_gap1", done_q[n0+1] - done_q[n0], FL);
      chk("loop_gap2", done_q[n0+2] - done_q[n0+1], FL);
    end
    apb_read(CA, d, e);
    chk("loop_ctrl", d, 8'h82);
    apb_write(CA, 8'h00);
    n1 = done_q.size();
    wait_count("loop_last", n1 + 1);
    repeat (FL + 100) @(posedge clk);
    chk("loop_stopped", done_q.size(), n1 + 1);
    apb_read(CA, d, e);
    chk("loop_idle", d, 8'h00);

    // Reset held three edges mid-TX.
    apb_write(CA, 8'h03);
    repeat (100) @(posedge clk);
    #1 rstn = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_neo", neo, 0);
    chk("rst_verbose", verb, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    apb_read(CA, d, e);
    chk("rst_ctrl_rd", d, 8'h00);

    rand_ops(6000, 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
